// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: opcodes and FSM states shared by the bit-serial ALU
package alu_serial_pkg;
  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_serial_ctrl_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice; carry is only produced for ADD/SUB
module alu_bit_slice
  import alu_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] opcode,
  output logic       r,
  output logic       cout
);
  logic arith;
  always_comb begin
    arith = (opcode == OP_ADD) || (opcode == OP_SUB);
    r = opcode == OP_NOT ? ~a :
        opcode == OP_AND ? a & b :
        opcode == OP_XOR ? a ^ b :
        arith            ? a ^ b ^ cin : 1'b0;
    cout = arith & ((a & b) | (cin & (a ^ b)));
  end
endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial WIDTH-bit ALU, LSB first, one bit per clock
// Define ALU_SERIAL_FLAGS_EN to add the zero and overflow outputs.
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             zero,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, shifted;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d, s_r, s_c;
`ifdef ALU_SERIAL_FLAGS_EN
  logic             zero_q, zero_d, overflow_q, overflow_d;
  assign zero     = zero_q;
  assign overflow = overflow_q;
`endif
  alu_bit_slice u_slice (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .cin    (carry_q),
    .opcode (op_q),
    .r      (s_r),
    .cout   (s_c)
  );
  assign shifted   = {s_r, result_q[WIDTH-1:1]};
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign result    = result_q;
  assign carry_out = carry_q;
  // b is stored pre-inverted for SUB so the slice always just adds
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
`ifdef ALU_SERIAL_FLAGS_EN
    zero_d     = zero_q;
    overflow_d = overflow_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        cnt_d    = '0;
        a_d      = a;
        b_d      = opcode == OP_SUB ? ~b : b;
        op_d     = opcode;
        carry_d  = opcode == OP_SUB;
        result_d = '0;
`ifdef ALU_SERIAL_FLAGS_EN
        zero_d     = 1'b0;
        overflow_d = 1'b0;
`endif
      end
      RUN: begin
        state_d  = cnt_q == LAST ? DONE : RUN;
        cnt_d    = cnt_q + CW'(1);
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        carry_d  = s_c;
        result_d = shifted;
`ifdef ALU_SERIAL_FLAGS_EN
        // on the MSB cycle carry_q is the carry into the MSB
        if (cnt_q == LAST) begin
          zero_d     = shifted == '0;
          overflow_d = (op_q == OP_ADD || op_q == OP_SUB) ? carry_q ^ s_c : 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
`ifdef ALU_SERIAL_FLAGS_EN
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
`ifdef ALU_SERIAL_FLAGS_EN
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
`endif
    end
  end
endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial N-bit ALU built around a single 1-bit ALU slice. It latches two WIDTH-bit operands and an opcode, then processes one bit per clock, LSB first. On each cycle it feeds the slice one operand bit pair plus the registered carry, and shifts the slice output into a result register. It sits directly upstream and downstream of the slice: it drives the slice's inputs and consumes its sum, carry and logic outputs.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH ≥ 2
- clk  input  1  rising-edge clock; one clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- opcode  input  3  000 NOT a, 001 AND, 010 XOR, 011 ADD, 100 SUB (a−b); 101–111 reserved
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result and flags valid
- result  output  WIDTH  assembled result; holds until the next accepted start
- carry_out  output  1  final carry for ADD/SUB (SUB: 1 = no borrow); 0 for all other opcodes
- zero, overflow  output  1 each  present only with ALU_SERIAL_FLAGS_EN

## Operation
- Reset state: FSM in IDLE.
- Reset values: busy=0, done=0, result=0, carry_out=0, zero=0, overflow=0, internal carry=0, bit counter=0.
- IDLE, start=1: latch a, b and opcode; clear the result shift register; set bit counter to 0.
  - Initial carry = 1 for SUB, else 0.
  - Next state: RUN.
- RUN, per cycle, at bit index i:
  - Slice inputs: a[i], b'[i] and the carry register. b' = ~b for SUB, b otherwise.
  - Slice output bit is shifted into result from the MSB side, so after WIDTH shifts bit 0 lands at result[0].
  - Carry register ← slice carry (ADD/SUB); forced to 0 for other opcodes.
  - Counter increments; when counter == WIDTH−1, next state is DONE.
- DONE: done=1 for exactly one cycle.
  - carry_out = final carry register.
  - Next state: IDLE unconditionally.
- Per-bit functions:
  - NOT: ~a[i].
  - AND: a[i]&b[i].
  - XOR: a[i]^b[i].
  - ADD/SUB: full-add sum of a[i], b'[i] and carry.
  - Reserved opcodes: the run still takes full length; output bits 0; carry 0.
- Start handling:
  - start in RUN or DONE is ignored, not queued.
  - A start held high is re-accepted on the first IDLE cycle.
- Reset asserted mid-operation aborts the run. All outputs take their reset values on the next edge; no done pulse.
- Operand inputs may change freely after acceptance; only latched copies are used.
- Arithmetic is modulo 2^WIDTH; no widening of result.

## Timing
- start sampled at edge T (IDLE).
- RUN occupies cycles T+1 … T+WIDTH.
- done=1 and result valid during cycle T+WIDTH+1.
- Earliest next acceptance is edge T+WIDTH+2, giving a throughput of WIDTH+2 cycles per operation.
- busy is high from T+1 through T+WIDTH+1 inclusive.
- result changes during RUN, because the shift register is visible. Consumers sample only when done=1.
- Bit counter width: $clog2(WIDTH).

## Configuration
- ALU_SERIAL_FLAGS_EN defined: adds the zero and overflow outputs, registered and valid with done.
  - zero = (result == 0), for every opcode.
  - overflow = carry into MSB XOR carry out of MSB, for ADD/SUB only; 0 otherwise.
  - The carry into the MSB is captured when counter == WIDTH−1.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package alu_serial_pkg holds:
  - opcode localparams OP_NOT, OP_AND, OP_XOR, OP_ADD, OP_SUB;
  - FSM state encoding IDLE/RUN/DONE (2 bits).
- One sub-module: alu_bit_slice, a combinational 1-bit slice.
  - Inputs: a, b, carry-in, opcode.
  - Outputs: result bit, carry-out.
  - Instantiated once.
- The FSM, counter, operand shift registers and result shift register live in alu_serial_ctrl.

## Test plan
- WIDTH=8: ADD a=0xFF, b=0x01 → result=0x00, carry_out=1, done exactly 9 cycles after the start edge, busy high for 9 cycles.
- SUB a=0x05, b=0x07 → result=0xFE, carry_out=0. Then SUB a=0x07, b=0x05 → result=0x02, carry_out=1.
- Logic ops, each with carry_out=0:
  - AND 0xA5&0x3C → 0x24;
  - XOR 0xA5^0x3C → 0x99;
  - NOT a=0x0F → 0xF0;
  - opcode 110 → 0x00.
- Start handling: start pulsed during RUN → ignored, one done only. start held high continuously → back-to-back operations, done pulses spaced 10 cycles apart.
- Reset mid-run: rst asserted in the 4th RUN cycle → next cycle all outputs 0, state IDLE, no done pulse. A fresh ADD 0x12+0x34 then gives 0x46.
- With ALU_SERIAL_FLAGS_EN:
  - ADD 0x7F+0x01 → 0x80, overflow=1, zero=0;
  - SUB 0x33−0x33 → 0x00, zero=1, carry_out=1, overflow=0.
